// File: rtl/interleaver_pkg.sv
// Shared types and size helpers for the block-interleaver controller.
// Optional deinterleave mode is enabled by defining ILV_DEINT_EN.
package interleaver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int calc_n(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int calc_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Cells are always numbered row-major, whatever order they are visited in.
    function automatic int idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/interleaver_ctrl_rc_counter.sv
// 2-D row/column position counter; the major-order input picks which
// coordinate advances first, so one counter serves both fill and drain.
module ilv_rc_counter
    import interleaver_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int RW   = $clog2(ROWS),
    parameter int CW   = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_i,
    input  logic          clear_i,
    input  logic          col_major_i,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          rowWrap;
    logic          colWrap;

    assign rowWrap = (row_q == RW'(ROWS - 1));
    assign colWrap = (col_q == CW'(COLS - 1));

    // Clear wins over step; at the last cell both coordinates wrap to zero together.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (step_i) begin
            if (col_major_i) begin
                row_d = rowWrap ? '0 : row_q + 1'b1;
                if (rowWrap) begin
                    col_d = colWrap ? '0 : col_q + 1'b1;
                end
            end else begin
                col_d = colWrap ? '0 : col_q + 1'b1;
                if (colWrap) begin
                    row_d = rowWrap ? '0 : row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = rowWrap && colWrap;

endmodule

// File: rtl/interleaver_ctrl.sv
// Fill/drain sequencer for a ROWS x COLS enable-flop bit matrix with one read mux.
// Define ILV_DEINT_EN to add the per-frame deint input that swaps the two orders.
module interleaver_ctrl
    import interleaver_pkg::*;
#(
    parameter  int ROWS = 4,
    parameter  int COLS = 4,
    localparam int N    = calc_n(ROWS, COLS),
    localparam int IW   = calc_iw(N)
) (
    input  logic          clk,
    input  logic          reset,
`ifdef ILV_DEINT_EN
    input  logic          deint,
`endif
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  wr_en,
    output logic [IW-1:0] rd_sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          frame_done,
    output logic          busy
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    state_e        state_q, state_d;
    logic          done_q, done_d;
    logic          wrote_q, wrote_d;
    logic          deintEff;
    logic          accept;
    logic          readEn;
    logic          clearCnt;
    logic          colMajor;
    logic          lastCell;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [IW-1:0] cellIdx;

    // Flush suppresses the handshake in the same cycle so nothing is written or consumed.
    assign accept   = (state_q == FILL)  && in_valid  && !flush;
    assign readEn   = (state_q == DRAIN) && out_ready && !flush;
    assign clearCnt = flush && (state_q != IDLE);
    assign colMajor = (state_q == DRAIN) ^ deintEff;
    assign cellIdx  = IW'(idx(int'(row), int'(col), COLS));

    ilv_rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW)
    ) u_rc_counter (
        .clk         (clk),
        .reset       (reset),
        .step_i      (accept || readEn),
        .clear_i     (clearCnt),
        .col_major_i (colMajor),
        .row_o       (row),
        .col_o       (col),
        .last_o      (lastCell)
    );

`ifdef ILV_DEINT_EN
    logic deint_q;
    logic deintSample;

    // Order is latched only at frame boundaries, so mid-frame changes of deint wait.
    assign deintSample = (state_q == IDLE) || clearCnt
                      || ((state_q == DRAIN) && readEn && lastCell);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deint_q <= 1'b0;
        end else if (deintSample) begin
            deint_q <= deint;
        end
    end

    assign deintEff = deint_q;
`else
    assign deintEff = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        wrote_d = wrote_q;
        unique case (state_q)
            IDLE: begin
                state_d = FILL;
                wrote_d = 1'b0;
            end
            FILL: begin
                if (flush) begin
                    wrote_d = 1'b0;
                end else if (accept) begin
                    wrote_d = 1'b1;
                    if (lastCell) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                wrote_d = 1'b0;
                if (flush) begin
                    state_d = FILL;
                end else if (readEn && lastCell) begin
                    state_d = FILL;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                wrote_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            wrote_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            wrote_q <= wrote_d;
        end
    end

    // The cell enable is combinational so the cell captures on the accepting edge.
    always_comb begin
        wr_en = '0;
        if (accept) begin
            wr_en[cellIdx] = 1'b1;
        end
    end

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == DRAIN);
    assign rd_sel     = (state_q == DRAIN) ? cellIdx : '0;
    assign frame_done = done_q;
    assign busy       = (state_q == DRAIN) || ((state_q == FILL) && wrote_q);

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Self-checking bench for interleaver_ctrl at ROWS=2, COLS=3: directed scenarios
// plus a randomized run against a position-count reference model.
module tb_interleaver_ctrl;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;
    localparam int IW   = $clog2(N);

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  wr_en;
    logic [IW-1:0] rd_sel;
    logic          out_valid;
    logic          out_ready;
    logic          frame_done;
    logic          busy;
`ifdef ILV_DEINT_EN
    logic          deint;
`endif

    int checks   = 0;
    int failures = 0;

    int rdExp[N] = '{0, 3, 1, 4, 2, 5};

    interleaver_ctrl #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ILV_DEINT_EN
        .deint      (deint),
`endif
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .rd_sel     (rd_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N-1:0] oneHot(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // k-th visit in column-major order, expressed as a row-major cell number
    function automatic int colMajorIdx(input int p);
        return (p % ROWS) * COLS + (p / ROWS);
    endfunction

    function automatic int fillIdx(input int p, input bit d);
        return d ? colMajorIdx(p) : p;
    endfunction

    function automatic int drainIdx(input int p, input bit d);
        return d ? p : colMajorIdx(p);
    endfunction

    task automatic applyReset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, frame_done} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {in_ready, out_valid, busy, frame_done});
        end
        checks++;
        if (wr_en !== '0 || rd_sel !== '0) begin
            failures++;
            $display("[TB] FAIL reset_buses: got wr_en=%b rd_sel=%0d expected 0/0", wr_en, rd_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || wr_en !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_entry: got in_ready=%b wr_en=%b out_valid=%b busy=%b expected 1/0/0/0",
                     in_ready, wr_en, out_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            #1;
            checks++;
            if (wr_en !== oneHot(i)) begin
                failures++;
                $display("[TB] FAIL fill_order[%0d]: got %b expected %b", i, wr_en, oneHot(i));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_entry: got out_valid=%b in_ready=%b busy=%b expected 1/0/1",
                     out_valid, in_ready, busy);
        end
        for (int i = 0; i < N; i++) begin
            out_ready = 1'b1;
            #1;
            checks++;
            if (rd_sel !== IW'(rdExp[i]) || frame_done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL drain_order[%0d]: got rd_sel=%0d done=%b expected %0d/0",
                         i, rd_sel, frame_done, rdExp[i]);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (frame_done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || rd_sel !== '0) begin
            failures++;
            $display("[TB] FAIL frame_done_pulse: got done=%b in_ready=%b out_valid=%b rd_sel=%0d expected 1/1/0/0",
                     frame_done, in_ready, out_valid, rd_sel);
        end
        @(negedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_done_width: got %b expected 0", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int      wr;
        int      rd;
        bit      rdyPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        wr = 0;
        for (int j = 0; j < 20 && wr < N; j++) begin
            in_valid = (j % 3) != 1;
            #1;
            checks++;
            if (wr_en !== (in_valid ? oneHot(wr) : '0)) begin
                failures++;
                $display("[TB] FAIL gap_fill[%0d]: got %b expected %b", j, wr_en,
                         in_valid ? oneHot(wr) : {N{1'b0}});
            end
            if (in_valid) wr++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (wr != N) begin
            failures++;
            $display("[TB] FAIL gap_fill_count: got %0d expected %0d", wr, N);
        end
        rd = 0;
        for (int j = 0; j < 30 && rd < N; j++) begin
            out_ready = rdyPat[j % 4];
            #1;
            checks++;
            if (out_valid !== 1'b1 || rd_sel !== IW'(rdExp[rd])) begin
                failures++;
                $display("[TB] FAIL stall_drain[%0d]: got valid=%b rd_sel=%0d expected 1/%0d",
                         j, out_valid, rd_sel, rdExp[rd]);
            end
            if (out_ready) rd++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (rd != N || frame_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_done: got reads=%0d done=%b expected %0d/1", rd, frame_done, N);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (wr_en !== '0) begin
            failures++;
            $display("[TB] FAIL flush_wr_block: got %b expected 0", wr_en);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || wr_en !== oneHot(0)) begin
            failures++;
            $display("[TB] FAIL flush_restart: got in_ready=%b busy=%b wr_en=%b expected 1/0/%b",
                     in_ready, busy, wr_en, oneHot(0));
        end
        @(negedge clk);
        for (int i = 1; i < N; i++) begin
            #1;
            checks++;
            if (wr_en !== oneHot(i)) begin
                failures++;
                $display("[TB] FAIL flush_refill[%0d]: got %b expected %b", i, wr_en, oneHot(i));
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || rd_sel !== IW'(rdExp[2])) begin
            failures++;
            $display("[TB] FAIL flush_drain_pre: got valid=%b rd_sel=%0d expected 1/%0d", out_valid, rd_sel, rdExp[2]);
        end
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1 || rd_sel !== '0) begin
            failures++;
            $display("[TB] FAIL flush_drain_post: got valid=%b done=%b in_ready=%b rd_sel=%0d expected 0/0/1/0",
                     out_valid, frame_done, in_ready, rd_sel);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        in_valid = 1'b1;
        repeat (N) @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, frame_done} !== 4'b0000 || rd_sel !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset: got ctrl=%b rd_sel=%0d expected 0000/0",
                     {out_valid, in_ready, busy, frame_done}, rd_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (frame_done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_idle: got done=%b in_ready=%b expected 0/0", frame_done, in_ready);
        end
        @(negedge clk);
    endtask

`ifdef ILV_DEINT_EN
    task automatic test_deint();
        deint = 1'b1;
        applyReset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            #1;
            checks++;
            if (wr_en !== oneHot(rdExp[i])) begin
                failures++;
                $display("[TB] FAIL deint_fill[%0d]: got %b expected %b", i, wr_en, oneHot(rdExp[i]));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        deint    = 1'b0;
        for (int i = 0; i < N; i++) begin
            out_ready = 1'b1;
            #1;
            checks++;
            if (rd_sel !== IW'(i)) begin
                failures++;
                $display("[TB] FAIL deint_drain[%0d]: got %0d expected %0d", i, rd_sel, i);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int           mState;
        int           mPos;
        bit           mWrote;
        bit           mDone;
        bit           mDeint;
        bit           dIn;
        logic [N-1:0] expWr;
        logic [IW-1:0] expRd;
        bit           expBusy;
        dIn = 1'b0;
`ifdef ILV_DEINT_EN
        deint = 1'($urandom_range(0, 1));
`endif
        applyReset();
        mState = 0;
        mPos   = 0;
        mWrote = 1'b0;
        mDone  = 1'b0;
        mDeint = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 31) == 0;
`ifdef ILV_DEINT_EN
            if ($urandom_range(0, 7) == 0) deint = ~deint;
            dIn = deint;
`endif
            #1;
            expWr = '0;
            if (mState == 1 && in_valid && !flush) expWr[fillIdx(mPos, mDeint)] = 1'b1;
            expRd   = (mState == 2) ? IW'(drainIdx(mPos, mDeint)) : '0;
            expBusy = (mState == 2) || (mState == 1 && mWrote);
            checks++;
            if (wr_en !== expWr) begin
                failures++;
                $display("[TB] FAIL rand_wr_en@%0d: got %b expected %b", cyc, wr_en, expWr);
            end
            checks++;
            if (rd_sel !== expRd) begin
                failures++;
                $display("[TB] FAIL rand_rd_sel@%0d: got %0d expected %0d", cyc, rd_sel, expRd);
            end
            checks++;
            if ({in_ready, out_valid, busy, frame_done} !== {mState == 1, mState == 2, expBusy, mDone}) begin
                failures++;
                $display("[TB] FAIL rand_ctrl@%0d: got %b expected %b", cyc,
                         {in_ready, out_valid, busy, frame_done}, {mState == 1, mState == 2, expBusy, mDone});
            end
            @(negedge clk);
            mDone = 1'b0;
            if (mState == 0) begin
                mState = 1;
                mPos   = 0;
                mDeint = dIn;
            end else if (flush) begin
                mState = 1;
                mPos   = 0;
                mWrote = 1'b0;
                mDeint = dIn;
            end else if (mState == 1 && in_valid) begin
                mPos++;
                mWrote = 1'b1;
                if (mPos == N) begin
                    mPos   = 0;
                    mState = 2;
                    mWrote = 1'b0;
                end
            end else if (mState == 2 && out_ready) begin
                mPos++;
                if (mPos == N) begin
                    mPos   = 0;
                    mState = 1;
                    mDone  = 1'b1;
                    mDeint = dIn;
                end
            end
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
`ifdef ILV_DEINT_EN
        deint = 1'b0;
`endif
        test_reset();
        test_fill_drain();
        test_backpressure();
        test_flush();
        test_reset_mid_drain();
`ifdef ILV_DEINT_EN
        test_deint();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
